// File: rtl/cop_cprs_wb_arbiter.sv
// Write-back arbiter for the coprocessor register file: round-robin grant of NREQ requesters
// into a one-entry registered write stage. Optional pair writes: define COP_WB_PAIR_EN.
module cop_cprs_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 4
) (
    input  logic                   vtx_clk,
    input  logic                   vtx_reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*2*XLEN-1:0] req_data,
    input  logic [NREQ-1:0]        req_pair,
    input  logic                   rf_stall,
    output logic                   rf_wen,
    output logic [AW-1:0]          rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic                   busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [AW-1:0]   stage_addr;
    logic [XLEN-1:0] stage_data;
    logic            hi_pending;

    logic            can_accept;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   next_ptr;
    int              idx_i;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_lo;

    // Handshake: a write transfers in any cycle where req_valid[i] && req_ready[i].
    // req_ready is combinational, one-hot or zero; requesters hold valid/addr/data until accepted.
    assign busy     = (state != IDLE);
    assign rf_wen   = busy && !rf_stall;
    assign rf_waddr = stage_addr;
    assign rf_wdata = stage_data;

    assign can_accept = !vtx_reset &&
                        ((state == IDLE) ||
                         (state == WR_LO && rf_wen && !hi_pending) ||
                         (state == WR_HI && rf_wen));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_i       = 0;
        req_ready   = '0;
        if (can_accept) begin
            for (int k = 0; k < NREQ; k++) begin
                idx_i = (int'(rr_ptr) + k) % NREQ;
                if (!grant_found && req_valid[idx_i]) begin
                    grant_found = 1'b1;
                    grant_idx   = PW'(idx_i);
                end
            end
        end
        if (grant_found) req_ready[grant_idx] = 1'b1;
    end

    assign next_ptr = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

    always_comb begin
        win_addr = '0;
        win_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                win_addr = req_addr[i*AW +: AW];
                win_lo   = req_data[i*2*XLEN +: XLEN];
            end
        end
    end

`ifdef COP_WB_PAIR_EN
    logic [AW-1:0]   hi_addr;
    logic [XLEN-1:0] hi_data;
    logic [XLEN-1:0] win_hi;
    logic            win_pair;

    always_comb begin
        win_hi   = '0;
        win_pair = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                win_hi   = req_data[i*2*XLEN + XLEN +: XLEN];
                win_pair = req_pair[i];
            end
        end
    end
`else
    logic unused_inputs;
    assign hi_pending    = 1'b0;
    assign unused_inputs = ^{req_pair, req_data};
`endif

    // Priority: pending high half first, then a new grant, else drain; a stalled full stage holds.
    always_ff @(posedge vtx_clk or posedge vtx_reset) begin
        if (vtx_reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            stage_addr <= '0;
            stage_data <= '0;
`ifdef COP_WB_PAIR_EN
            hi_pending <= 1'b0;
            hi_addr    <= '0;
            hi_data    <= '0;
`endif
        end else begin
`ifdef COP_WB_PAIR_EN
            if (state == WR_LO && rf_wen && hi_pending) begin
                state      <= WR_HI;
                stage_addr <= hi_addr;
                stage_data <= hi_data;
                hi_pending <= 1'b0;
            end else
`endif
            if (grant_found) begin
                state      <= WR_LO;
                stage_data <= win_lo;
                rr_ptr     <= next_ptr;
`ifdef COP_WB_PAIR_EN
                stage_addr <= win_pair ? (win_addr & ~AW'(1)) : win_addr;
                hi_pending <= win_pair;
                hi_addr    <= win_addr | AW'(1);
                hi_data    <= win_hi;
`else
                stage_addr <= win_addr;
`endif
            end else if (rf_wen) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cop_cprs_wb_arbiter.sv
// Directed bench for cop_cprs_wb_arbiter: reset, single write, round-robin, stall, pair/no-pair.
module tb_cop_cprs_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*2*XLEN-1:0] req_data;
    logic [NREQ-1:0]        req_pair;
    logic                   rf_stall;
    logic                   rf_wen;
    logic [AW-1:0]          rf_waddr;
    logic [XLEN-1:0]        rf_wdata;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    cop_cprs_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .vtx_clk   (clk),
        .vtx_reset (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_pair  (req_pair),
        .rf_stall  (rf_stall),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] lo,
                           input logic [XLEN-1:0] hi, input logic pair);
        req_addr[i*AW +: AW]               = a;
        req_data[i*2*XLEN +: XLEN]         = lo;
        req_data[i*2*XLEN + XLEN +: XLEN]  = hi;
        req_pair[i]                        = pair;
    endtask

    // Move to the next falling edge, then let combinational outputs settle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_wr(input string tag, input logic wen, input logic [AW-1:0] a,
                            input logic [XLEN-1:0] d);
        check({tag, "_wen"}, 64'(rf_wen), 64'(wen));
        if (wen) begin
            check({tag, "_waddr"}, 64'(rf_waddr), 64'(a));
            check({tag, "_wdata"}, 64'(rf_wdata), 64'(d));
        end
    endtask

    initial begin
        logic [AW-1:0]   rr_addr [NREQ];
        logic [XLEN-1:0] rr_data [NREQ];

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_pair  = '0;
        rf_stall  = 1'b0;
        repeat (2) next_cycle();
        settle();
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_ready_held", 64'(req_ready), 64'd0);
        next_cycle();
        rst = 1'b0;

        // Single write from requester 1.
        next_cycle();
        set_req(1, 4'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        req_valid = 3'b010;
        settle();
        check("single_ready", 64'(req_ready), 64'b010);
        next_cycle();
        req_valid = '0;
        settle();
        check_wr("single_wr", 1'b1, 4'd5, 32'hDEADBEEF);
        check("single_busy", 64'(busy), 64'd1);
        check("single_ready_after", 64'(req_ready), 64'd0);
        next_cycle();
        settle();
        check("single_idle_wen", 64'(rf_wen), 64'd0);
        check("single_idle_busy", 64'(busy), 64'd0);

        // Reset asserted while a write sits in WR_LO (rr_ptr was advanced to 1 by this grant).
        next_cycle();
        set_req(0, 4'd3, 32'h12345678, 32'h0, 1'b0);
        req_valid = 3'b001;
        settle();
        check("rmid_ready", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = '0;
        settle();
        check_wr("rmid_pre", 1'b1, 4'd3, 32'h12345678);
        rst = 1'b1;
        settle();
        check("rmid_wen", 64'(rf_wen), 64'd0);
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_waddr", 64'(rf_waddr), 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        settle();
        check("rmid_post_wen", 64'(rf_wen), 64'd0);
        check("rmid_post_busy", 64'(busy), 64'd0);

        // Round-robin: all three valid for six grants; rr_ptr=0 after reset so order is 0,1,2,...
        for (int i = 0; i < NREQ; i++) begin
            rr_addr[i] = AW'(i + 1);
            rr_data[i] = 32'hA0 + XLEN'(i);
            set_req(i, rr_addr[i], rr_data[i], 32'h0, 1'b0);
        end
        next_cycle();
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle();
            check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
            if (c > 0)
                check_wr($sformatf("rr_wr_c%0d", c), 1'b1, rr_addr[(c-1)%3], rr_data[(c-1)%3]);
            next_cycle();
        end
        req_valid = '0;
        settle();
        check_wr("rr_last", 1'b1, rr_addr[2], rr_data[2]);
        check("rr_last_ready", 64'(req_ready), 64'd0);
        next_cycle();
        settle();
        check("rr_idle_busy", 64'(busy), 64'd0);

        // Pair write from requester 0 with requester 1 waiting (rr_ptr=0).
        set_req(0, 4'd7, 32'h22222222, 32'h11111111, 1'b1);
        set_req(1, 4'd10, 32'h33333333, 32'h0, 1'b0);
`ifdef COP_WB_PAIR_EN
        req_valid = 3'b011;
        settle();
        check("pair_ready0", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = 3'b010;
        settle();
        check_wr("pair_lo", 1'b1, 4'd6, 32'h22222222);
        check("pair_lo_ready", 64'(req_ready), 64'd0);
        next_cycle();
        settle();
        check_wr("pair_hi", 1'b1, 4'd7, 32'h11111111);
        check("pair_hi_ready", 64'(req_ready), 64'b010);
        next_cycle();
        req_valid = '0;
        settle();
        check_wr("pair_next", 1'b1, 4'd10, 32'h33333333);
        next_cycle();
        settle();
        check("pair_idle_busy", 64'(busy), 64'd0);
`else
        req_valid = 3'b001;
        settle();
        check("nopair_ready", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = '0;
        settle();
        check_wr("nopair_wr", 1'b1, 4'd7, 32'h22222222);
        check("nopair_busy", 64'(busy), 64'd1);
        next_cycle();
        settle();
        check("nopair_idle_wen", 64'(rf_wen), 64'd0);
        check("nopair_idle_busy", 64'(busy), 64'd0);
`endif
        set_req(0, 4'd0, 32'h0, 32'h0, 1'b0);

        // Stall: fill the stage from requester 1, then hold rf_stall with requester 0 waiting.
        next_cycle();
        set_req(1, 4'd9, 32'hB1, 32'h0, 1'b0);
        req_valid = 3'b010;
        settle();
        check("stall_fill_ready", 64'(req_ready), 64'b010);
        next_cycle();
        set_req(0, 4'd4, 32'hC0, 32'h0, 1'b0);
        req_valid = 3'b001;
        rf_stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("stall_wen_c%0d", c), 64'(rf_wen), 64'd0);
            check($sformatf("stall_ready_c%0d", c), 64'(req_ready), 64'd0);
            check($sformatf("stall_busy_c%0d", c), 64'(busy), 64'd1);
            check($sformatf("stall_waddr_c%0d", c), 64'(rf_waddr), 64'd9);
            check($sformatf("stall_wdata_c%0d", c), 64'(rf_wdata), 64'hB1);
            next_cycle();
        end
        rf_stall = 1'b0;
        settle();
        check_wr("stall_release", 1'b1, 4'd9, 32'hB1);
        check("stall_release_ready", 64'(req_ready), 64'b001);
        next_cycle();
        req_valid = '0;
        settle();
        check_wr("stall_next", 1'b1, 4'd4, 32'hC0);
        next_cycle();
        settle();
        check("stall_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: sim time exceeded, expected finish");
        $fatal(1, "timeout");
    end

endmodule
